// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 4-lane FFT: bit-reversed groups in, natural-order groups out.
// Two N-entry banks ping-pong between the write side and the read FSM.
module fft_out_reorder #(
  parameter int NBITS_OUT = 15,
  parameter int N         = 128,
  parameter int LOGN      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [2*NBITS_OUT-1:0] fftIn0_up,
  input  logic [2*NBITS_OUT-1:0] fftIn0_down,
  input  logic [2*NBITS_OUT-1:0] fftIn1_up,
  input  logic [2*NBITS_OUT-1:0] fftIn1_down,
  output logic [2*NBITS_OUT-1:0] fftOut0,
  output logic [2*NBITS_OUT-1:0] fftOut1,
  output logic [2*NBITS_OUT-1:0] fftOut2,
  output logic [2*NBITS_OUT-1:0] fftOut3,
  output logic                   o_valid,
  output logic                   o_sof,
  output logic                   o_ovf
);

  localparam int W2 = 2 * NBITS_OUT;
  localparam int KW = LOGN - 2;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = x[LOGN-1-b];
    return r;
  endfunction

  logic [W2-1:0]   bank_mem [2][N];
  logic [W2-1:0]   lane_in  [4];
  logic [LOGN-1:0] wr_addr  [4];

  logic [KW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [KW-1:0] rd_cnt_q, rd_cnt_d;
  logic [W2-1:0] out_q [4];
  logic [W2-1:0] out_d [4];
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          ovf_q, ovf_d;
  logic          wr_last, rd_last;

  always_comb begin
    lane_in[0] = fftIn0_up;
    lane_in[1] = fftIn0_down;
    lane_in[2] = fftIn1_up;
    lane_in[3] = fftIn1_down;
    for (int j = 0; j < 4; j++) wr_addr[j] = bitrev({wr_cnt_q, 2'(j)});
  end

  always_ff @(posedge clk) begin
    if (i_enable && !rst) begin
      for (int j = 0; j < 4; j++) bank_mem[wr_bank_q][wr_addr[j]] <= lane_in[j];
    end
  end

  assign wr_last = (wr_cnt_q == '1);
  assign rd_last = (rd_state_q == RD_READ) && (rd_cnt_q == '1);

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    full_d     = full_q;
    ovf_d      = ovf_q;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    for (int i = 0; i < 4; i++) out_d[i] = out_q[i];

    if (rd_last) full_d[rd_bank_q] = 1'b0;

    if (i_enable) begin
      // A bank whose last group is read out on this same edge is already free:
      // the new frame's first group lands on entries the reader has finished with.
      if ((wr_cnt_q == '0) && full_q[wr_bank_q] && !(rd_last && (rd_bank_q == wr_bank_q)))
        ovf_d = 1'b1;
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    unique case (rd_state_q)
      RD_IDLE: begin
        valid_d = 1'b0;
        sof_d   = 1'b0;
        if (full_q[0] || full_q[1]) begin
          rd_state_d = RD_READ;
          rd_bank_d  = !full_q[0];
          rd_cnt_d   = '0;
        end
      end
      RD_READ: begin
        for (int i = 0; i < 4; i++) out_d[i] = bank_mem[rd_bank_q][{rd_cnt_q, 2'(i)}];
        valid_d  = 1'b1;
        sof_d    = (rd_cnt_q == '0);
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_last) begin
          if (full_q[~rd_bank_q]) rd_bank_d = ~rd_bank_q;
          else rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      ovf_q      <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
    end
  end

  assign fftOut0 = out_q[0];
  assign fftOut1 = out_q[1];
  assign fftOut2 = out_q[2];
  assign fftOut3 = out_q[3];
  assign o_valid = valid_q;
  assign o_sof   = sof_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: frame-level reference model (arrival order -> natural bin order)
// feeding an expected-output queue, scenario table, and hand-written corner sequences.
module tb_fft_out_reorder;

  localparam int NB   = 15;
  localparam int N    = 128;
  localparam int LOGN = 7;
  localparam int W2   = 2 * NB;
  localparam int G    = N / 4;
  localparam int W    = 1 + 4 * W2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_enable;
  logic [W2-1:0] in0, in1, in2, in3;
  logic [W2-1:0] fftOut0, fftOut1, fftOut2, fftOut3;
  logic          o_valid, o_sof, o_ovf;

  fft_out_reorder #(.NBITS_OUT(NB), .N(N), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .fftIn0_up(in0), .fftIn0_down(in1), .fftIn1_up(in2), .fftIn1_down(in3),
    .fftOut0(fftOut0), .fftOut1(fftOut1), .fftOut2(fftOut2), .fftOut3(fftOut3),
    .o_valid(o_valid), .o_sof(o_sof), .o_ovf(o_ovf)
  );

  // scoreboard and statistics
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic [W-1:0]  exp_q[$];
  logic [W2-1:0] frame_q[$];
  logic [W2-1:0] lane_in[4];
  int            valid_total = 0, sof_total = 0, rise_total = 0;
  int            last_sof_cyc = 0, last_valid_cyc = 0, last_frame_cyc = 0;
  bit            prev_valid = 1'b0;
  bit            mon_en = 1'b1;

  typedef struct {
    int frames;
    int stall_pct;
    int exp_valid;
    int exp_sof;
    int exp_rises;   // -1: not constrained
  } scen_t;
  scen_t tbl[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Natural bin b came in at arrival position brev(b).
  task automatic push_frame();
    logic [W-1:0] w;
    for (int m = 0; m < G; m++) begin
      w = {(m == 0), frame_q[brev(4*m)], frame_q[brev(4*m+1)],
           frame_q[brev(4*m+2)], frame_q[brev(4*m+3)]};
      exp_q.push_back(w);
    end
    frame_q.delete();
  endtask

  task automatic monitor();
    if (mon_en) begin
      if (o_valid) begin
        valid_total++;
        last_valid_cyc = cyc;
        if (!prev_valid) rise_total++;
        if (o_sof) begin
          sof_total++;
          last_sof_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output cyc=%0d actual=valid required=idle", cyc);
        end else begin
          check("data", 128'({o_sof, fftOut0, fftOut1, fftOut2, fftOut3}), 128'(exp_q.pop_front()));
        end
      end else begin
        check("sof_without_valid", 128'(o_sof), 128'(0));
      end
      check("ovf_low", 128'(o_ovf), 128'(0));
    end
    prev_valid = o_valid;
  endtask

  // driver: one clock cycle with the given enable/reset, model updated at the sampling edge
  task automatic tick(input logic en, input logic r);
    rst = r;
    i_enable = en;
    in0 = lane_in[0];
    in1 = lane_in[1];
    in2 = lane_in[2];
    in3 = lane_in[3];
    @(posedge clk);
    cyc++;
    if (r) begin
      frame_q.delete();
      exp_q.delete();
    end else if (en) begin
      for (int j = 0; j < 4; j++) frame_q.push_back(lane_in[j]);
      if (frame_q.size() == N) begin
        push_frame();
        last_frame_cyc = cyc;
      end
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic rand_lanes();
    for (int j = 0; j < 4; j++) lane_in[j] = W2'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int j = 0; j < 4; j++) lane_in[j] = '0;
    repeat (n) tick(1'b0, 1'b1);
  endtask

  task automatic send_frame(input int pct);
    for (int k = 0; k < G; k++) begin
      while ($urandom_range(99) < pct) tick(1'b0, 1'b0);
      rand_lanes();
      tick(1'b1, 1'b0);
    end
  endtask

  task automatic flush();
    int b = 0;
    while ((exp_q.size() != 0 || o_valid) && b < 300) begin
      tick(1'b0, 1'b0);
      b++;
    end
    if (b >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL flush_timeout cyc=%0d actual=%0d_pending required=0", cyc, exp_q.size());
    end
  endtask

  initial begin
    int v0, s0, r0;
    logic [NB-1:0] re;

    tbl[0] = '{frames: 1, stall_pct: 0,  exp_valid: 32,  exp_sof: 1, exp_rises: 1};
    tbl[1] = '{frames: 4, stall_pct: 0,  exp_valid: 128, exp_sof: 4, exp_rises: 1};
    tbl[2] = '{frames: 2, stall_pct: 30, exp_valid: 64,  exp_sof: 2, exp_rises: -1};
    tbl[3] = '{frames: 3, stall_pct: 30, exp_valid: 96,  exp_sof: 3, exp_rises: -1};
    tbl[4] = '{frames: 2, stall_pct: 10, exp_valid: 64,  exp_sof: 2, exp_rises: -1};

    rst = 1'b1;
    i_enable = 1'b0;
    for (int j = 0; j < 4; j++) lane_in[j] = '0;

    // reset / idle
    do_reset(3);
    check("reset_flags", 128'({o_valid, o_sof, o_ovf}), 128'(0));
    check("reset_data", 128'({fftOut0, fftOut1, fftOut2, fftOut3}), 128'(0));
    for (int c = 0; c < 50; c++) begin
      tick(1'b0, 1'b0);
      check("idle_flags", 128'({o_valid, o_sof, o_ovf}), 128'(0));
      check("idle_data", 128'({fftOut0, fftOut1, fftOut2, fftOut3}), 128'(0));
    end

    // single ramp frame: re = 4k+j, im = -(4k+j); latency from the last group
    do_reset(2);
    repeat (7) tick(1'b0, 1'b0);
    v0 = valid_total;
    s0 = sof_total;
    for (int k = 0; k < G; k++) begin
      for (int j = 0; j < 4; j++) begin
        re = NB'(4 * k + j);
        lane_in[j] = {re, -re};
      end
      tick(1'b1, 1'b0);
    end
    flush();
    check("ramp_first_valid", 128'(last_sof_cyc - last_frame_cyc), 128'(2));
    check("ramp_last_valid", 128'(last_valid_cyc - last_frame_cyc), 128'(G + 1));
    check("ramp_valid_count", 128'(valid_total - v0), 128'(G));
    check("ramp_sof_count", 128'(sof_total - s0), 128'(1));

    // scenario table: random data, continuous and stalled streaming
    for (int s = 0; s < 5; s++) begin
      do_reset(2);
      v0 = valid_total;
      s0 = sof_total;
      r0 = rise_total;
      for (int f = 0; f < tbl[s].frames; f++) send_frame(tbl[s].stall_pct);
      flush();
      check("scen_valid", 128'(valid_total - v0), 128'(tbl[s].exp_valid));
      check("scen_sof", 128'(sof_total - s0), 128'(tbl[s].exp_sof));
      if (tbl[s].exp_rises >= 0) check("scen_unbroken", 128'(rise_total - r0), 128'(tbl[s].exp_rises));
      check("scen_ovf", 128'(o_ovf), 128'(0));
    end

    // reset after group 17 of a frame, then one clean frame
    do_reset(2);
    v0 = valid_total;
    s0 = sof_total;
    for (int k = 0; k < 18; k++) begin
      rand_lanes();
      tick(1'b1, 1'b0);
    end
    tick(1'b0, 1'b1);
    send_frame(0);
    flush();
    check("midrst_valid", 128'(valid_total - v0), 128'(G));
    check("midrst_sof", 128'(sof_total - s0), 128'(1));

    // overflow: both banks forced full, first group of a frame arrives
    do_reset(2);
    check("ovf_before", 128'(o_ovf), 128'(0));
    mon_en = 1'b0;
    force dut.full_q = 2'b11;
    rand_lanes();
    tick(1'b1, 1'b0);
    check("ovf_rise", 128'(o_ovf), 128'(1));
    release dut.full_q;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0);
      check("ovf_sticky", 128'(o_ovf), 128'(1));
    end
    tick(1'b0, 1'b1);
    check("ovf_after_rst", 128'({o_ovf, o_valid, o_sof}), 128'(0));
    mon_en = 1'b1;
    send_frame(0);
    flush();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
